// File: rtl/bus_arbiter_2_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding,
// the error read-data constant and the request bundle carried on each port.
package bus_arbiter_2_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // Read data handed back when the watchdog terminates a transaction.
    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    // One request bundle: what a master presents and what the host port carries.
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data_write;
        logic [3:0]  write_mask;
        logic        ren;
        logic        wen;
    } bus_req_t;

    localparam bus_req_t BUS_REQ_NONE = '{
        address:    32'h0000_0000,
        data_write: 32'h0000_0000,
        write_mask: 4'b0000,
        ren:        1'b0,
        wen:        1'b0
    };

    // Round-robin pick: a lone requester wins, on contention the master
    // that was not served last wins.
    function automatic arb_state_t arbitrate(input logic req0,
                                             input logic req1,
                                             input logic last);
        arb_state_t pick;
        if (req0 && req1) begin
            pick = (last == 1'b1) ? GRANT0 : GRANT1;
        end else if (req0) begin
            pick = GRANT0;
        end else if (req1) begin
            pick = GRANT1;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating cycle counter for the arbiter watchdog. clr has priority over
// en; expire is high while the count sits at TIMEOUT-1, i.e. in the
// TIMEOUT-th enabled cycle after a clear.
module bus_watchdog
    import bus_arbiter_2_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT   = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] ZERO  = CW'(0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear, count up to the saturation value, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = ZERO;
        end else if (en && (count_q != SAT)) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry flag decoded straight from the count.
    always_comb begin
        expire = (count_q == LIMIT);
    end

endmodule

// File: rtl/bus_arbiter_2.sv
// Two-master round-robin arbiter in front of the bus hub host port.
// m0 is instruction fetch, m1 is load/store. A grant lasts one transaction;
// ready from the hub is passed combinationally to the granted master, and a
// watchdog forces an error completion when no device answers.
module bus_arbiter_2
    import bus_arbiter_2_pkg::*;
#(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = BUS_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_data_write,
    input  logic [3:0]  m0_write_mask,
    input  logic        m0_ren,
    input  logic        m0_wen,
    output logic [31:0] m0_data_read,
    output logic        m0_ready,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_data_write,
    input  logic [3:0]  m1_write_mask,
    input  logic        m1_ren,
    input  logic        m1_wen,
    output logic [31:0] m1_data_read,
    output logic        m1_ready,
    output logic [31:0] bus_address,
    output logic [31:0] bus_data_write,
    output logic [3:0]  bus_write_mask,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [31:0] bus_data_read,
    input  logic        bus_ready,
    output logic        timeout_err
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_q;
    logic       last_d;

    bus_req_t   m0_req_s;
    bus_req_t   m1_req_s;
    bus_req_t   gnt_req_s;
    logic       req0_s;
    logic       req1_s;
    logic       granted_s;
    logic       gnt_id_s;
    logic       gnt_active_s;
    logic       done_real_s;
    logic       to_fire_s;
    logic       complete_s;
    logic       wd_expire_s;
    logic       wd_en_s;
    logic       wd_clr_s;

    // Bundle master inputs and select the one owning the host port.
    always_comb begin
        m0_req_s = '{address: m0_address, data_write: m0_data_write,
                     write_mask: m0_write_mask, ren: m0_ren, wen: m0_wen};
        m1_req_s = '{address: m1_address, data_write: m1_data_write,
                     write_mask: m1_write_mask, ren: m1_ren, wen: m1_wen};
        req0_s   = m0_ren | m0_wen;
        req1_s   = m1_ren | m1_wen;
        granted_s = 1'b0;
        gnt_id_s  = 1'b0;
        gnt_req_s = BUS_REQ_NONE;
        case (state_q)
            GRANT0: begin
                granted_s = 1'b1;
                gnt_id_s  = 1'b0;
                gnt_req_s = m0_req_s;
            end
            GRANT1: begin
                granted_s = 1'b1;
                gnt_id_s  = 1'b1;
                gnt_req_s = m1_req_s;
            end
            default: begin
                granted_s = 1'b0;
                gnt_id_s  = 1'b0;
                gnt_req_s = BUS_REQ_NONE;
            end
        endcase
    end

    // Completion decode; a real hub ready always beats a watchdog expiry.
    always_comb begin
        gnt_active_s = granted_s & (gnt_req_s.ren | gnt_req_s.wen);
        done_real_s  = gnt_active_s & bus_ready;
        to_fire_s    = gnt_active_s & ~bus_ready & wd_expire_s;
        complete_s   = done_real_s | to_fire_s;
        wd_en_s      = gnt_active_s & ~complete_s;
        wd_clr_s     = ~wd_en_s;
    end

    // Watchdog counts only while a grant is still pending; any other cycle
    // clears it so every new grant starts from zero.
    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr_s),
        .en     (wd_en_s),
        .expire (wd_expire_s)
    );

    // Next-state and round-robin pointer. At a completion edge the finishing
    // master still holds the request it was just served for, so it is masked
    // out of re-arbitration; otherwise it would be granted a second time.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                state_d = arbitrate(req0_s, req1_s, last_q);
            end
            GRANT0, GRANT1: begin
                if (complete_s) begin
                    last_d  = gnt_id_s;
                    state_d = arbitrate(req0_s & gnt_id_s, req1_s & ~gnt_id_s, gnt_id_s);
                end else if (!gnt_active_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and pointer registers; last resets to 1 so m0 wins first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Host-port mirror and per-master responses; everything is zero in IDLE,
    // which also covers the asynchronous reset case.
    always_comb begin
        bus_address    = gnt_req_s.address;
        bus_data_write = gnt_req_s.data_write;
        bus_write_mask = gnt_req_s.write_mask;
        bus_ren        = gnt_req_s.ren;
        bus_wen        = gnt_req_s.wen;
        timeout_err    = to_fire_s;
        m0_ready       = 1'b0;
        m0_data_read   = 32'h0000_0000;
        m1_ready       = 1'b0;
        m1_data_read   = 32'h0000_0000;
        if (granted_s && !gnt_id_s) begin
            m0_ready     = complete_s;
            m0_data_read = to_fire_s ? ERR_DATA : bus_data_read;
        end else if (granted_s && gnt_id_s) begin
            m1_ready     = complete_s;
            m1_data_read = to_fire_s ? ERR_DATA : bus_data_read;
        end else begin
            m0_ready     = 1'b0;
            m1_ready     = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2.sv
// Scoreboard bench for bus_arbiter_2 (TIMEOUT = 8). Expected completions are
// queued when the master stimulus is applied; a negedge monitor pops one
// entry per ready pulse and compares master, data and timeout_err.
module tb_bus_arbiter_2;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address, m0_data_write, m0_data_read;
    logic [3:0]  m0_write_mask;
    logic        m0_ren, m0_wen, m0_ready;
    logic [31:0] m1_address, m1_data_write, m1_data_read;
    logic [3:0]  m1_write_mask;
    logic        m1_ren, m1_wen, m1_ready;
    logic [31:0] bus_address, bus_data_write, bus_data_read;
    logic [3:0]  bus_write_mask;
    logic        bus_ren, bus_wen, bus_ready, timeout_err;

    bus_arbiter_2 #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_data_write(m0_data_write),
        .m0_write_mask(m0_write_mask), .m0_ren(m0_ren), .m0_wen(m0_wen),
        .m0_data_read(m0_data_read), .m0_ready(m0_ready),
        .m1_address(m1_address), .m1_data_write(m1_data_write),
        .m1_write_mask(m1_write_mask), .m1_ren(m1_ren), .m1_wen(m1_wen),
        .m1_data_read(m1_data_read), .m1_ready(m1_ready),
        .bus_address(bus_address), .bus_data_write(bus_data_write),
        .bus_write_mask(bus_write_mask), .bus_ren(bus_ren), .bus_wen(bus_wen),
        .bus_data_read(bus_data_read), .bus_ready(bus_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [31:0] data;
        logic        to;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] d, input logic to);
        exp_t e;
        e.m = m; e.data = d; e.to = to;
        sb_q.push_back(e);
    endtask

    task automatic set_m(input int m, input logic ren, input logic wen,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] mk);
        if (m == 0) begin
            m0_ren = ren; m0_wen = wen; m0_address = a; m0_data_write = d; m0_write_mask = mk;
        end else begin
            m1_ren = ren; m1_wen = wen; m1_address = a; m1_data_write = d; m1_write_mask = mk;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic any_out();
        return |{m0_data_read, m1_data_read, m0_ready, m1_ready, bus_address,
                 bus_data_write, bus_write_mask, bus_ren, bus_wen, timeout_err};
    endfunction

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
                check("rdy_both", 32'(m0_ready & m1_ready), 32'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 32'({m1_ready, m0_ready}), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rdy_master", 32'(m1_ready), 32'(e.m));
                    check("rdy_data", m1_ready ? m1_data_read : m0_data_read, e.data);
                    check("rdy_timeout_err", 32'(timeout_err), 32'(e.to));
                    check("other_data_zero", m1_ready ? m0_data_read : m1_data_read, 32'd0);
                end
            end else if (timeout_err !== 1'b0) begin
                check("stray_timeout_err", 32'(timeout_err), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_m(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_m(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_ready = 1'b0;
        bus_data_read = 32'h0000_0000;
        smp();
        check("rst_outputs_zero", 32'(any_out()), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Contention right after reset: m0 first, then alternate with no gap.
        set_m(0, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 4'd0);
        set_m(1, 1'b0, 1'b1, 32'h0000_0300, 32'hCAFE_0001, 4'b0011);
        push_exp(0, 32'h5555_0000, 1'b0);
        push_exp(1, 32'h5555_0001, 1'b0);
        bus_ready = 1'b1;
        smp();
        check("ct_idle_ren", 32'(bus_ren), 32'd0);
        check("ct_idle_wen", 32'(bus_wen), 32'd0);
        tick();
        bus_data_read = 32'h5555_0000;
        smp();
        check("ct_g0_addr", bus_address, 32'h0000_0200);
        check("ct_g0_ren", 32'(bus_ren), 32'd1);
        tick();
        set_m(0, 1'b1, 1'b0, 32'h0000_0204, 32'd0, 4'd0);
        push_exp(0, 32'h5555_0002, 1'b0);
        bus_data_read = 32'h5555_0001;
        smp();
        check("ct_g1_addr", bus_address, 32'h0000_0300);
        check("ct_g1_wen", 32'(bus_wen), 32'd1);
        check("ct_g1_wdata", bus_data_write, 32'hCAFE_0001);
        check("ct_g1_mask", 32'(bus_write_mask), 32'h3);
        tick();
        set_m(1, 1'b0, 1'b1, 32'h0000_0304, 32'hCAFE_0003, 4'b1111);
        push_exp(1, 32'h5555_0003, 1'b0);
        bus_data_read = 32'h5555_0002;
        smp();
        check("ct_g0b_addr", bus_address, 32'h0000_0204);
        tick();
        set_m(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_data_read = 32'h5555_0003;
        smp();
        check("ct_g1b_addr", bus_address, 32'h0000_0304);
        check("ct_g1b_wdata", bus_data_write, 32'hCAFE_0003);
        tick();
        set_m(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_ready = 1'b0;
        smp();
        check("ct_end_idle", 32'({bus_ren, bus_wen}), 32'd0);

        // Single m0 read, hub answers in the first grant cycle.
        tick();
        set_m(0, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'd0);
        push_exp(0, 32'h1234_5678, 1'b0);
        bus_ready = 1'b1;
        bus_data_read = 32'h1234_5678;
        smp();
        check("sg_idle_ren", 32'(bus_ren), 32'd0);
        tick();
        smp();
        check("sg_ren", 32'(bus_ren), 32'd1);
        check("sg_addr", bus_address, 32'h0000_0100);
        check("sg_m1_ready", 32'(m1_ready), 32'd0);
        tick();
        set_m(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_ready = 1'b0;
        smp();
        check("sg_ren_done", 32'(bus_ren), 32'd0);

        // Wait states: m1 read stalls 5 cycles while m0 waits behind it.
        tick();
        set_m(1, 1'b1, 1'b0, 32'h0000_0400, 32'd0, 4'd0);
        bus_data_read = 32'h0BAD_0BAD;
        smp();
        tick();
        set_m(0, 1'b1, 1'b0, 32'h0000_0500, 32'd0, 4'd0);
        push_exp(1, 32'hA5A5_0006, 1'b0);
        push_exp(0, 32'h0B0B_0000, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            smp();
            check("ws_addr", bus_address, 32'h0000_0400);
            check("ws_m1_ready", 32'(m1_ready), 32'd0);
            check("ws_m0_ready", 32'(m0_ready), 32'd0);
            tick();
        end
        bus_ready = 1'b1;
        bus_data_read = 32'hA5A5_0006;
        smp();
        check("ws_addr6", bus_address, 32'h0000_0400);
        tick();
        set_m(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_data_read = 32'h0B0B_0000;
        smp();
        check("ws_m0_addr", bus_address, 32'h0000_0500);
        tick();
        set_m(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_ready = 1'b0;
        smp();

        // Timeout: no bus_ready, forced error on the 8th grant cycle.
        tick();
        set_m(0, 1'b1, 1'b0, 32'h0000_0600, 32'd0, 4'd0);
        push_exp(0, 32'hDEAD_BEEF, 1'b1);
        bus_data_read = 32'h7777_7777;
        smp();
        tick();
        for (int c = 1; c < TO; c++) begin
            smp();
            check("to_early_err", 32'(timeout_err), 32'd0);
            check("to_early_ready", 32'(m0_ready), 32'd0);
            tick();
        end
        smp();
        check("to_fire_ren", 32'(bus_ren), 32'd1);
        // m0 issues its next read immediately; the arbiter passes via IDLE.
        tick();
        set_m(0, 1'b1, 1'b0, 32'h0000_0604, 32'd0, 4'd0);
        push_exp(0, 32'h8888_0008, 1'b0);
        smp();
        check("to_next_idle", 32'(bus_ren), 32'd0);
        tick();
        for (int c = 1; c < TO; c++) begin
            smp();
            check("to2_early_ready", 32'(m0_ready), 32'd0);
            tick();
        end
        bus_ready = 1'b1;
        bus_data_read = 32'h8888_0008;
        smp();
        tick();
        set_m(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_ready = 1'b0;
        smp();
        check("to2_end_ren", 32'(bus_ren), 32'd0);

        // Abandonment: m1 drops its write after two grant cycles.
        tick();
        set_m(1, 1'b0, 1'b1, 32'h0000_0700, 32'h7070_7070, 4'b1010);
        smp();
        tick();
        smp();
        check("ab_wen1", 32'(bus_wen), 32'd1);
        tick();
        smp();
        check("ab_wen2", 32'(bus_wen), 32'd1);
        tick();
        set_m(1, 1'b0, 1'b0, 32'h0000_0700, 32'h7070_7070, 4'b1010);
        set_m(0, 1'b1, 1'b0, 32'h0000_0800, 32'd0, 4'd0);
        push_exp(0, 32'h9999_0009, 1'b0);
        bus_ready = 1'b1;
        bus_data_read = 32'h9999_0009;
        smp();
        check("ab_no_ready", 32'(m1_ready), 32'd0);
        check("ab_wen_low", 32'(bus_wen), 32'd0);
        tick();
        smp();
        check("ab_idle_ren", 32'(bus_ren), 32'd0);
        check("ab_idle_wen", 32'(bus_wen), 32'd0);
        tick();
        smp();
        check("ab_m0_ren", 32'(bus_ren), 32'd1);
        tick();
        set_m(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_ready = 1'b0;
        smp();

        // Async reset mid-transaction, then contention goes to m0 again.
        tick();
        set_m(0, 1'b1, 1'b0, 32'h0000_0A00, 32'd0, 4'd0);
        smp();
        tick();
        smp();
        check("ar_pre_ren", 32'(bus_ren), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_outputs_zero", 32'(any_out()), 32'd0);
        #1 rst = 1'b0;
        set_m(1, 1'b1, 1'b0, 32'h0000_0B00, 32'd0, 4'd0);
        push_exp(0, 32'hC0C0_000C, 1'b0);
        push_exp(1, 32'hD0D0_000D, 1'b0);
        tick();
        smp();
        tick();
        bus_ready = 1'b1;
        bus_data_read = 32'hC0C0_000C;
        smp();
        check("ar_first_addr", bus_address, 32'h0000_0A00);
        tick();
        set_m(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_data_read = 32'hD0D0_000D;
        smp();
        check("ar_second_addr", bus_address, 32'h0000_0B00);
        tick();
        set_m(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_ready = 1'b0;
        smp();
        check("ar_end_idle", 32'({bus_ren, bus_wen}), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
